// File: rtl/delay_pkg.sv
// Shared constants and helpers for the parameterised delay line.
package delay_pkg;

  localparam int unsigned DEPTH_MAX = 64;
  localparam int unsigned WIDTH_MAX = 64;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One pipeline stage: a W-bit register with shift enable and synchronous clears.
module delay_stage #(
  parameter int unsigned W = 3
) (
  input  logic         sys_clk_i,
  input  logic         sys_rst_i,
  input  logic         ce_i,
  input  logic         flush_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d = '0;
    end else if (ce_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/param_delay_line.sv
// Shift-register delay line with a runtime-selectable tap, valid tracking and fill counter.
module param_delay_line
  import delay_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned SEL_W = clog2(DEPTH + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             ce,
  input  logic             flush,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] tap_sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [SEL_W-1:0] fill_cnt,
  output logic             primed
);

  localparam logic [SEL_W-1:0] DepthSel = SEL_W'(DEPTH);

  // Each stage word carries the valid bit in its MSB.
  logic [WIDTH:0] stage_q [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH:0] stage_d;
    if (i == 0) begin : g_head
      assign stage_d = {in_valid, in};
    end else begin : g_body
      assign stage_d = stage_q[i-1];
    end

    delay_stage #(
      .W(WIDTH + 1)
    ) u_stage (
      .sys_clk_i(sys_clk),
      .sys_rst_i(sys_rst),
      .ce_i     (ce),
      .flush_i  (flush),
      .d_i      (stage_d),
      .q_o      (stage_q[i])
    );
  end

  logic [SEL_W-1:0] fill_cnt_d, fill_cnt_q;

  always_comb begin
    fill_cnt_d = fill_cnt_q;
    if (flush) begin
      fill_cnt_d = '0;
    end else if (ce && in_valid && (fill_cnt_q < DepthSel)) begin
      fill_cnt_d = fill_cnt_q + SEL_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      fill_cnt_q <= '0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
    end
  end

  logic [SEL_W-1:0] tap_eff;
  logic [SEL_W-1:0] tap_idx;
  logic [WIDTH:0]   sel_word;

  always_comb begin
    tap_eff = tap_sel;
    if (tap_sel == '0) begin
      tap_eff = SEL_W'(1);
    end else if (tap_sel > DepthSel) begin
      tap_eff = DepthSel;
    end
  end

  assign tap_idx = tap_eff - SEL_W'(1);

  // Read-only mux over the stage registers; the input never reaches out combinationally.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (tap_idx == SEL_W'(i)) begin
        sel_word = stage_q[i];
      end
    end
  end

  assign out       = sel_word[WIDTH-1:0];
  assign out_valid = sel_word[WIDTH];
  assign fill_cnt  = fill_cnt_q;
  assign primed    = (fill_cnt_q >= tap_eff);

endmodule

// File: tb/tb_param_delay_line.sv
// Scoreboard bench: history-queue reference model feeds expectations to a negedge monitor.
module tb_param_delay_line;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned SW = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst, ce, flush, in_valid;
  logic [W-1:0]  in;
  logic [SW-1:0] tap_sel;
  logic [W-1:0]  out;
  logic          out_valid;
  logic [SW-1:0] fill_cnt;
  logic          primed;

  param_delay_line #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .ce       (ce),
    .flush    (flush),
    .in       (in),
    .in_valid (in_valid),
    .tap_sel  (tap_sel),
    .out      (out),
    .out_valid(out_valid),
    .fill_cnt (fill_cnt),
    .primed   (primed)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [W-1:0]  data;
    logic          vld;
    logic [SW-1:0] fill;
    logic          primed;
  } exp_t;

  exp_t        exp_q[$];
  logic [W:0]  hist[$];  // index 0 = most recently accepted sample, {valid, data}
  int          fill_m;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < int'(D); i++) hist.push_back('0);
    fill_m = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Called at posedge+1: expectation for the current register state, then model the next edge.
  task automatic step(input bit r, input bit f, input bit c, input logic [W-1:0] d,
                      input bit v, input logic [SW-1:0] t);
    exp_t e;
    int   tap;
    sys_rst = r; flush = f; ce = c; in = d; in_valid = v; tap_sel = t;
    tap = int'(t);
    if (tap == 0) tap = 1;
    if (tap > int'(D)) tap = int'(D);
    e.data   = hist[tap-1][W-1:0];
    e.vld    = hist[tap-1][W];
    e.fill   = SW'(fill_m);
    e.primed = (fill_m >= tap);
    exp_q.push_back(e);
    if (r || f) begin
      model_clear();
    end else if (c) begin
      hist.push_front({v, d});
      void'(hist.pop_back());
      if (v && fill_m < int'(D)) fill_m++;
    end
    @(posedge sys_clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out",       64'(out),       64'(e.data));
        chk("out_valid", 64'(out_valid), 64'(e.vld));
        chk("fill_cnt",  64'(fill_cnt),  64'(e.fill));
        chk("primed",    64'(primed),    64'(e.primed));
      end
    end
  end

  initial begin : stimulus
    sys_rst = 1'b1; ce = 1'b0; flush = 1'b0; in = '0; in_valid = 1'b0; tap_sel = 3'd2;
    repeat (2) @(posedge sys_clk);
    #1;
    model_clear();

    // Reset state, then a short stream at tap 2.
    step(1, 0, 0, 8'h00, 0, 3'd2);
    step(0, 0, 1, 8'h01, 1, 3'd2);
    step(0, 0, 1, 8'h02, 1, 3'd2);
    step(0, 0, 1, 8'h03, 1, 3'd2);
    step(0, 0, 1, 8'h00, 0, 3'd2);
    step(0, 0, 1, 8'h00, 0, 3'd2);

    // Stall between two samples at tap 3; input toggles while ce is low.
    step(0, 0, 1, 8'hA1, 1, 3'd3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, W'($urandom), 1, 3'd3);
    step(0, 0, 1, 8'hB2, 1, 3'd3);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00, 0, 3'd3);

    // Continuous stream with a tap switch mid-way (6 clamps to DEPTH).
    for (int i = 0; i < 16; i++) step(0, 0, 1, W'(i), 1, (i < 10) ? 3'd2 : 3'd6);

    // Flush together with ce discards the 0x05 sample; tap 7 and tap 0 exercise the clamp.
    step(0, 1, 1, 8'h05, 1, 3'd7);
    step(0, 0, 1, 8'h11, 1, 3'd7);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'h20 + W'(i), 1, 3'd7);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h30 + W'(i), 1, 3'd0);

    // Saturation then a mid-stream reset.
    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'h40 + W'(i), 1, 3'd3);
    step(1, 0, 1, 8'h77, 1, 3'd3);
    step(0, 0, 0, 8'h00, 0, 3'd3);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(39) == 0), ($urandom_range(19) == 0), ($urandom_range(3) != 0),
           W'($urandom), ($urandom_range(3) != 0), SW'($urandom_range(7)));
    end
    step(0, 0, 0, 8'h00, 0, 3'd1);

    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("drain", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
